// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions.
//  jk_code_t  : 2-bit {J,K} excitation code.
//  jk_excite  : derives the {J,K} code that moves a cell from q to nxt.
//               Don't-cares resolve to 0, so JK_TGL is never produced.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_code_t;

  function automatic jk_code_t jk_excite(input logic q, input logic nxt);
    // Set only on a 0->1 move, clear only on a 1->0 move.
    return jk_code_t'({~q & nxt, q & ~nxt});
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with complementary outputs.
//  clk     in  rising-edge clock
//  reset_n in  async active-low clear (q=0, q_bar=1)
//  j, k    in  excitation: 00 hold, 01 clear, 10 set, 11 toggle
//  q       out stored bit
//  q_bar   out complement, kept in its own register
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  logic q_q;
  logic qb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q  <= 1'b0;
      qb_q <= 1'b1;
    end else begin
      case (jk_code_t'({j, k}))
        JK_SET:  begin q_q <= 1'b1;  qb_q <= 1'b0; end
        JK_CLR:  begin q_q <= 1'b0;  qb_q <= 1'b1; end
        JK_TGL:  begin q_q <= ~q_q;  qb_q <= q_q;  end
        default: begin q_q <= q_q;   qb_q <= qb_q; end
      endcase
    end
  end

  assign q     = q_q;
  assign q_bar = qb_q;

endmodule

// File: rtl/jk_excite_counter.sv
// Up/down modulo-MODULUS counter built from a bank of JK cells.
// The desired next count is computed first, then turned into per-bit
// J/K excitation which drives the cells.
//  clk       in   rising-edge clock
//  reset_n   in   async active-low reset
//  en        in   count enable
//  up        in   1 = increment, 0 = decrement
//  load      in   synchronous load (beats en), value clamped to MODULUS-1
//  load_val  in   value to load
//  q         out  current count
//  q_bar     out  registered complement of q
//  j_vec     out  J excitation for the coming edge
//  k_vec     out  K excitation for the coming edge
//  tc        out  terminal count in the current direction
//  wrap      out  one-cycle pulse the cycle after a counting wrap
module jk_excite_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             wrap
);

  // Arithmetic is one bit wider than the count so MODULUS == 2**WIDTH
  // still has a representable terminal value and +1 cannot overflow.
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

  logic [WIDTH:0]   q_x;
  logic [WIDTH:0]   inc_x;
  logic [WIDTH:0]   dec_x;
  logic [WIDTH-1:0] nxt_d;
  logic             at_max;
  logic             at_zero;
  logic             wrap_q;

  assign q_x     = {1'b0, q};
  assign inc_x   = q_x + ONE_X;
  assign dec_x   = q_x - ONE_X;
  assign at_max  = (q_x == MAX_X);
  assign at_zero = (q_x == '0);

  always_comb begin
    nxt_d = q;
    if (load) begin
      nxt_d = ({1'b0, load_val} > MAX_X) ? MAX_X[WIDTH-1:0] : load_val;
    end else if (en && up) begin
      nxt_d = at_max ? '0 : inc_x[WIDTH-1:0];
    end else if (en) begin
      nxt_d = at_zero ? MAX_X[WIDTH-1:0] : dec_x[WIDTH-1:0];
    end
  end

  assign tc = up ? at_max : at_zero;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign {j_vec[gi], k_vec[gi]} = jk_excite(q[gi], nxt_d[gi]);

      jk_cell u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .j       (j_vec[gi]),
        .k       (k_vec[gi]),
        .q       (q[gi]),
        .q_bar   (q_bar[gi])
      );
    end
  endgenerate

  // Only a counting step across the terminal value is a wrap; loads never are.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wrap_q <= 1'b0;
    else          wrap_q <= en & ~load & tc;
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_excite_counter.sv
module tb_jk_excite_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, up, load;
  logic [3:0] load_val;

  logic [3:0] q, q_bar, j_vec, k_vec;
  logic       tc, wrap;
  logic [3:0] q16, q_bar16, j16, k16;
  logic       tc16, wrap16;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  jk_excite_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q), .q_bar(q_bar), .j_vec(j_vec),
    .k_vec(k_vec), .tc(tc), .wrap(wrap)
  );

  jk_excite_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q16), .q_bar(q_bar16), .j_vec(j16),
    .k_vec(k16), .tc(tc16), .wrap(wrap16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, check J/K never overlap.
  task automatic step();
    @(posedge clk);
    #1;
    chk("jk_overlap10", {28'd0, j_vec & k_vec}, 32'd0);
    chk("jk_overlap16", {28'd0, j16 & k16}, 32'd0);
  endtask

  task automatic chk_q(input string tag, input logic [3:0] eq, input logic ew);
    chk({tag, "_q"},    {28'd0, q},     {28'd0, eq});
    chk({tag, "_qbar"}, {28'd0, q_bar}, {28'd0, ~eq});
    chk({tag, "_wrap"}, {31'd0, wrap},  {31'd0, ew});
  endtask

  initial begin
    reset_n = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
    #1 reset_n = 1'b0;
    #1;
    // Reset state
    chk_q("reset", 4'd0, 1'b0);
    chk("reset_j", {28'd0, j_vec}, 32'd0);
    chk("reset_k", {28'd0, k_vec}, 32'd0);
    chk("reset_tc", {31'd0, tc}, 32'd0);
    chk("reset_q16", {28'd0, q16}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1; up = 1'b1;

    // Count up through the wrap
    for (int n = 1; n <= 12; n++) begin
      step();
      chk_q($sformatf("up%0d", n), 4'(n % 10), n == 10);
      chk($sformatf("up%0d_tc", n), {31'd0, tc}, {31'd0, (n % 10) == 9});
    end

    // Load 7 with en high: load wins, no wrap
    @(negedge clk); load = 1'b1; load_val = 4'd7;
    step();
    chk_q("load7", 4'd7, 1'b0);
    chk("load7_qbar_lit", {28'd0, q_bar}, 32'h8);
    @(negedge clk); load = 1'b0;
    #1;
    chk("exc7_j", {28'd0, j_vec}, 32'h8);
    chk("exc7_k", {28'd0, k_vec}, 32'h7);

    // Clamped load
    load = 1'b1; load_val = 4'd12;
    step();
    chk_q("load12", 4'd9, 1'b0);

    // Hold at 5
    @(negedge clk); load_val = 4'd5;
    step();
    chk_q("load5", 4'd5, 1'b0);
    @(negedge clk); load = 1'b0; en = 1'b0;
    #1;
    chk("hold_j", {28'd0, j_vec}, 32'd0);
    chk("hold_k", {28'd0, k_vec}, 32'd0);
    step();
    chk_q("hold5", 4'd5, 1'b0);

    // Down from 0 wraps to 9
    @(negedge clk); load = 1'b1; load_val = 4'd0; en = 1'b1;
    step();
    chk_q("load0", 4'd0, 1'b0);
    @(negedge clk); load = 1'b0; up = 1'b0;
    #1;
    chk("down0_tc", {31'd0, tc}, 32'd1);
    step();
    chk_q("down9", 4'd9, 1'b1);
    step();
    chk_q("down8", 4'd8, 1'b0);

    // Load while tc is high never wraps
    @(negedge clk); load = 1'b1; load_val = 4'd9; up = 1'b1;
    step();
    chk_q("load9", 4'd9, 1'b0);
    chk("load9_tc", {31'd0, tc}, 32'd1);
    @(negedge clk); load_val = 4'd3;
    step();
    chk_q("load3_at_tc", 4'd3, 1'b0);

    // Async reset mid-cycle at q=6
    @(negedge clk); load_val = 4'd6;
    step();
    chk_q("load6", 4'd6, 1'b0);
    load = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_q("midreset", 4'd0, 1'b0);
    @(negedge clk); reset_n = 1'b1;
    step();
    chk_q("resume", 4'd1, 1'b0);

    // Full-range modulus wraps 15 -> 0
    @(negedge clk); load = 1'b1; load_val = 4'd15;
    step();
    chk("m16_q15", {28'd0, q16}, 32'd15);
    chk("m16_tc", {31'd0, tc16}, 32'd1);
    chk("m10_clamp", {28'd0, q}, 32'd9);
    @(negedge clk); load = 1'b0;
    step();
    chk("m16_q0", {28'd0, q16}, 32'd0);
    chk("m16_qbar", {28'd0, q_bar16}, 32'hF);
    chk("m16_wrap", {31'd0, wrap16}, 32'd1);
    chk_q("m10_wrap", 4'd0, 1'b1);
    step();
    chk("m16_q1", {28'd0, q16}, 32'd1);
    chk("m16_wrap_off", {31'd0, wrap16}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
